// File: rtl/monitor_pkg.sv
// Shared constants and types for the SPI bus monitor.
// Holds the command opcodes, the frame-level FSM state type,
// the synchroniser depth and a byte-rounding helper.
package monitor_pkg;

  localparam logic [7:0] CMD_NOP        = 8'h00;
  localparam logic [7:0] CMD_WRITE_ISIG = 8'h01;
  localparam logic [7:0] CMD_SET_TRIG   = 8'h02;

  localparam int SYNC_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  // Number of whole bytes needed to carry a field of the given bit width.
  function automatic int bytesFor(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/monitor_spi_sync.sv
// SPI input synchronisers and edge detection for the bus monitor.
// SCK, MOSI and SS share the same synchroniser depth, so the MOSI value seen
// together with an SCK edge pulse is the value present when SCK moved.
// The SS chain resets to "selected" so that a select held low across reset
// release is never mistaken for a fresh frame start.
module monitor_spi_sync
  import monitor_pkg::*;
(
  input  logic i_clk,
  input  logic i_rstN,
  input  logic i_sck,
  input  logic i_si,
  input  logic i_ss,
  output logic o_sckRise,
  output logic o_sckFall,
  output logic o_ssFall,
  output logic o_ssRise,
  output logic o_si
);

  logic [SYNC_DEPTH-1:0] r_sckSync;
  logic [SYNC_DEPTH-1:0] r_siSync;
  logic [SYNC_DEPTH-1:0] r_ssSync;
  logic                  r_sckPrev;
  logic                  r_ssPrev;
  logic                  w_sck;
  logic                  w_ss;

  assign w_sck = r_sckSync[SYNC_DEPTH-1];
  assign w_ss  = r_ssSync[SYNC_DEPTH-1];

  // Shift the asynchronous SPI pins into the MCLK domain and keep last values for edge detection.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_sckSync <= '0;
      r_siSync  <= '0;
      r_ssSync  <= '0;
      r_sckPrev <= 1'b0;
      r_ssPrev  <= 1'b0;
    end else begin
      r_sckSync <= {r_sckSync[SYNC_DEPTH-2:0], i_sck};
      r_siSync  <= {r_siSync[SYNC_DEPTH-2:0], i_si};
      r_ssSync  <= {r_ssSync[SYNC_DEPTH-2:0], i_ss};
      r_sckPrev <= w_sck;
      r_ssPrev  <= w_ss;
    end
  end

  assign o_sckRise = w_sck & ~r_sckPrev;
  assign o_sckFall = ~w_sck & r_sckPrev;
  assign o_ssFall  = ~w_ss & r_ssPrev;
  assign o_ssRise  = w_ss & ~r_ssPrev;
  assign o_si      = r_siSync[SYNC_DEPTH-1];

endmodule

// File: rtl/spi_bus_monitor.sv
// SPI slave that snapshots a parallel bus and streams it out on MISO
// (mode 1, LSB first), while accepting commands on MOSI that drive the
// INPUT_SIGNAL register.
// Optional feature: define MONITOR_TRIGGER_EN to enable the address trigger
// (opcode 0x02 arms a comparator; the first bus cycle whose address matches
// freezes the snapshot returned by later frames and raises TRIG_HIT).
module spi_bus_monitor
  import monitor_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16,
  parameter int OSIG_W = 4,
  parameter int ISIG_W = 4
) (
  input  logic              MCLK_IN,
  input  logic              RESET_N_IN,
  input  logic              SPICLK_IN,
  input  logic              SPISI_IN,
  input  logic              SPISS_IN,
  input  logic [ADDR_W-1:0] ADDR_IN,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic [OSIG_W-1:0] OUTPUT_SIGNAL_IN,
  output logic [ISIG_W-1:0] INPUT_SIGNAL,
  output logic              SPISO,
  output logic              TRIG_HIT
);

  localparam int SNAP_W    = ((ADDR_W + DATA_W + OSIG_W + 7) / 8) * 8;
  localparam int ISIG_BITS = bytesFor(ISIG_W) * 8;
`ifdef MONITOR_TRIGGER_EN
  localparam int   TRIG_BITS = bytesFor(ADDR_W) * 8;
  localparam logic TRIG_EN   = 1'b1;
`else
  localparam int   TRIG_BITS = 0;
  localparam logic TRIG_EN   = 1'b0;
`endif
  localparam int PLD_W = (ISIG_BITS > TRIG_BITS) ? ISIG_BITS : TRIG_BITS;
  localparam int CNT_W = $clog2(PLD_W + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              w_sckRise;
  logic              w_sckFall;
  logic              w_ssFall;
  logic              w_ssRise;
  logic              w_si;

  state_t            r_state;
  logic [CNT_W-1:0]  r_bitCnt;
  logic [CNT_W-1:0]  r_payBits;
  logic [7:0]        r_cmd;
  logic [PLD_W-1:0]  r_payload;
  logic [SNAP_W-1:0] r_shift;
  logic [ISIG_W-1:0] r_isig;
  logic              r_miso;

  logic [7:0]        w_cmdNext;
  logic [PLD_W-1:0]  w_payloadNext;
  logic [CNT_W-1:0]  w_bitCntInc;
  logic              w_lastPayBit;
  logic [SNAP_W-1:0] w_snap;
  logic [SNAP_W-1:0] w_frameSnap;
  logic              w_unusedBits;

  monitor_spi_sync u_sync (
    .i_clk     (MCLK_IN),
    .i_rstN    (RESET_N_IN),
    .i_sck     (SPICLK_IN),
    .i_si      (SPISI_IN),
    .i_ss      (SPISS_IN),
    .o_sckRise (w_sckRise),
    .o_sckFall (w_sckFall),
    .o_ssFall  (w_ssFall),
    .o_ssRise  (w_ssRise),
    .o_si      (w_si)
  );

  assign w_snap       = SNAP_W'({OUTPUT_SIGNAL_IN, DATA_IN, ADDR_IN});
  assign w_cmdNext    = {w_si, r_cmd[7:1]};
  assign w_bitCntInc  = (r_bitCnt == CNT_MAX) ? r_bitCnt : r_bitCnt + CNT_W'(1);
  assign w_lastPayBit = (r_bitCnt == r_payBits - CNT_W'(1));
  assign w_unusedBits = ^w_payloadNext;

  // Payload arrives little endian, LSB first, so the running bit count is the bit position.
  always_comb begin
    w_payloadNext = r_payload;
    for (int i = 0; i < PLD_W; i++) begin
      if (r_bitCnt == CNT_W'(i)) begin
        w_payloadNext[i] = w_si;
      end
    end
  end

  // Frame FSM: snapshot on select, stream MISO on SCK rise, decode MOSI on SCK fall.
  always_ff @(posedge MCLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      r_state   <= ST_IDLE;
      r_bitCnt  <= '0;
      r_payBits <= '0;
      r_cmd     <= '0;
      r_payload <= '0;
      r_shift   <= '0;
      r_isig    <= '0;
      r_miso    <= 1'b0;
    end else if (w_ssRise) begin
      r_state  <= ST_IDLE;
      r_bitCnt <= '0;
      r_miso   <= 1'b0;
    end else begin
      if ((r_state != ST_IDLE) && w_sckRise) begin
        r_miso  <= r_shift[0];
        r_shift <= r_shift >> 1;
      end
      case (r_state)
        ST_IDLE: begin
          r_miso <= 1'b0;
          if (w_ssFall) begin
            r_state   <= ST_CMD;
            r_shift   <= w_frameSnap;
            r_bitCnt  <= '0;
            r_cmd     <= '0;
            r_payload <= '0;
          end
        end
        ST_CMD: begin
          if (w_sckFall) begin
            r_cmd    <= w_cmdNext;
            r_bitCnt <= w_bitCntInc;
            if (r_bitCnt == CNT_W'(7)) begin
              if (w_cmdNext == CMD_WRITE_ISIG) begin
                r_state   <= ST_PAYLOAD;
                r_payBits <= CNT_W'(ISIG_BITS);
                r_bitCnt  <= '0;
              end else if (TRIG_EN && (w_cmdNext == CMD_SET_TRIG)) begin
                r_state   <= ST_PAYLOAD;
                r_payBits <= CNT_W'(TRIG_BITS);
                r_bitCnt  <= '0;
              end else begin
                r_state <= ST_DRAIN;
              end
            end
          end
        end
        ST_PAYLOAD: begin
          if (w_sckFall) begin
            r_payload <= w_payloadNext;
            r_bitCnt  <= w_bitCntInc;
            if (w_lastPayBit) begin
              r_state <= ST_DRAIN;
              if (r_cmd == CMD_WRITE_ISIG) begin
                r_isig <= w_payloadNext[ISIG_W-1:0];
              end
            end
          end
        end
        ST_DRAIN: begin
          if (w_sckFall) begin
            r_bitCnt <= w_bitCntInc;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef MONITOR_TRIGGER_EN
  logic [ADDR_W-1:0] r_trigAddr;
  logic              r_armed;
  logic              r_trigHit;
  logic [SNAP_W-1:0] r_trigSnap;
  logic              w_armTrig;

  assign w_armTrig = (r_state == ST_PAYLOAD) && w_sckFall && !w_ssRise &&
                     w_lastPayBit && (r_cmd == CMD_SET_TRIG);

  // Arm on a completed set-trigger payload; freeze the bus on the first matching address.
  always_ff @(posedge MCLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      r_trigAddr <= '0;
      r_armed    <= 1'b0;
      r_trigHit  <= 1'b0;
      r_trigSnap <= '0;
    end else if (w_armTrig) begin
      r_trigAddr <= w_payloadNext[ADDR_W-1:0];
      r_armed    <= 1'b1;
      r_trigHit  <= 1'b0;
    end else if (r_armed && (ADDR_IN == r_trigAddr)) begin
      r_trigSnap <= w_snap;
      r_trigHit  <= 1'b1;
      r_armed    <= 1'b0;
    end
  end

  assign w_frameSnap = r_trigHit ? r_trigSnap : w_snap;
  assign TRIG_HIT    = r_trigHit;
`else
  assign w_frameSnap = w_snap;
  assign TRIG_HIT    = 1'b0;
`endif

  assign INPUT_SIGNAL = r_isig;
  assign SPISO        = r_miso;

endmodule
